// File: rtl/nikhilam_divider_16bit.sv
// Sequential 16-bit unsigned divider: Nikhilam base-complement reduction near 10/100/1000,
// with an optional radix-2 restoring fallback compiled in by NIKHILAM_RESTORE_EN.
module nikhilam_divider_16bit #(
  parameter int unsigned MAX_ITER = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] dividend,
  input  logic [15:0] divisor,
  input  logic [7:0]  pow10,
  input  logic        near,
  output logic        busy,
  output logic        done,
  output logic [15:0] quotient,
  output logic [15:0] remainder,
  output logic        dbz,
  output logic        err
);

  localparam int unsigned CntW = (MAX_ITER < 2) ? 1 : $clog2(MAX_ITER + 1);

  typedef enum logic [2:0] {StIdle, StIter, StCorr, StRdiv, StDone} state_e;

  state_e          state_q;
  logic [15:0]     a_q, d_q, q_q;
  logic [9:0]      b_q;
  logic [16:0]     c_q, r_q;
  logic [CntW-1:0] cnt_q;

  logic [9:0]      base_in;
  logic [16:0]     k, m, kc, r_step;
  logic [CntW-1:0] cnt_inc;

  always_comb begin
    case (pow10)
      8'd10:   base_in = 10'd10;
      8'd100:  base_in = 10'd100;
      8'hE8:   base_in = 10'd1000;
      default: base_in = 10'd0;
    endcase
  end

  // One reduction step: r = (r / B) * c + (r % B), with B a constant per mux leg.
  always_comb begin
    case (b_q)
      10'd10: begin
        k = r_q / 17'd10;
        m = r_q % 17'd10;
      end
      10'd100: begin
        k = r_q / 17'd100;
        m = r_q % 17'd100;
      end
      default: begin
        k = r_q / 17'd1000;
        m = r_q % 17'd1000;
      end
    endcase
    kc      = k * c_q;
    r_step  = kc + m;
    cnt_inc = cnt_q + CntW'(1);
  end

`ifdef NIKHILAM_RESTORE_EN
  logic [15:0] sh_q;
  logic [3:0]  bit_q;
  logic [16:0] pr, pr_nxt;
  logic [15:0] qr_nxt;

  always_comb begin
    pr = {r_q[15:0], sh_q[15]};
    if (pr >= {1'b0, d_q}) begin
      pr_nxt = pr - {1'b0, d_q};
      qr_nxt = {q_q[14:0], 1'b1};
    end else begin
      pr_nxt = pr;
      qr_nxt = {q_q[14:0], 1'b0};
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      busy      <= 1'b0;
      done      <= 1'b0;
      dbz       <= 1'b0;
      err       <= 1'b0;
      quotient  <= 16'd0;
      remainder <= 16'd0;
      a_q       <= 16'd0;
      d_q       <= 16'd0;
      q_q       <= 16'd0;
      b_q       <= 10'd0;
      c_q       <= 17'd0;
      r_q       <= 17'd0;
      cnt_q     <= '0;
`ifdef NIKHILAM_RESTORE_EN
      sh_q      <= 16'd0;
      bit_q     <= 4'd0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          done <= 1'b0;
          if (start) begin
            a_q   <= dividend;
            d_q   <= divisor;
            b_q   <= base_in;
            c_q   <= {7'd0, base_in} - {1'b0, divisor};
            q_q   <= 16'd0;
            r_q   <= {1'b0, dividend};
            cnt_q <= '0;
            dbz   <= 1'b0;
            err   <= 1'b0;
            busy  <= 1'b1;
            if (divisor == 16'd0) begin
              quotient  <= 16'hFFFF;
              remainder <= dividend;
              dbz       <= 1'b1;
              done      <= 1'b1;
              state_q   <= StDone;
            end else if (near && base_in != 10'd0 && divisor <= {6'd0, base_in}) begin
              state_q <= StIter;
            end else begin
`ifdef NIKHILAM_RESTORE_EN
              r_q     <= 17'd0;
              sh_q    <= dividend;
              bit_q   <= 4'd0;
              state_q <= StRdiv;
`else
              quotient  <= 16'd0;
              remainder <= dividend;
              err       <= 1'b1;
              done      <= 1'b1;
              state_q   <= StDone;
`endif
            end
          end
        end
        StIter: begin
          if (r_q < {7'd0, b_q}) begin
            state_q <= StCorr;
          end else begin
            q_q   <= q_q + k[15:0];
            r_q   <= r_step;
            cnt_q <= cnt_inc;
            if (cnt_inc == CntW'(MAX_ITER) && r_step >= {7'd0, b_q}) begin
              quotient  <= 16'd0;
              remainder <= a_q;
              err       <= 1'b1;
              done      <= 1'b1;
              state_q   <= StDone;
            end
          end
        end
        StCorr: begin
          // c < 0.3B keeps the leftover below 2*divisor, so one subtract suffices.
          if (r_q >= {1'b0, d_q}) begin
            quotient  <= q_q + 16'd1;
            remainder <= r_q[15:0] - d_q;
          end else begin
            quotient  <= q_q;
            remainder <= r_q[15:0];
          end
          done    <= 1'b1;
          state_q <= StDone;
        end
`ifdef NIKHILAM_RESTORE_EN
        StRdiv: begin
          r_q   <= pr_nxt;
          q_q   <= qr_nxt;
          sh_q  <= {sh_q[14:0], 1'b0};
          bit_q <= bit_q + 4'd1;
          if (bit_q == 4'd15) begin
            quotient  <= qr_nxt;
            remainder <= pr_nxt[15:0];
            done      <= 1'b1;
            state_q   <= StDone;
          end
        end
`endif
        StDone: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/nikhilam_divider_16bit.md
# nikhilam_divider_16bit

Sequential 16-bit unsigned divider that sits directly downstream of the 16-bit divisor analyzer in the dhvajanka datapath. It consumes the analyzer's nearest-power-of-10 and near-flag outputs. When the divisor is at or just below 10, 100 or 1000, it divides by iterative Nikhilam base-complement reduction; otherwise it uses a radix-2 restoring fallback. Results return over a start/busy/done handshake.

## Interface
Parameters:
- MAX_ITER, default 15: iteration guard for the Nikhilam loop.

Ports:
- clk  in  1  single clock; all state is updated on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request. Sampled only while busy=0.
- dividend  in  16  unsigned dividend, latched on an accepted start.
- divisor  in  16  unsigned divisor, latched on an accepted start.
- pow10  in  8  analyzer power-of-10 code: 8'd10 means 10, 8'd100 means 100, 8'hE8 means 1000. Any other value means "no base".
- near  in  1  analyzer is_near_power10 flag.
- busy  out  1  high from the cycle after an accepted start through the DONE cycle.
- done  out  1  one-cycle pulse when the result is valid.
- quotient  out  16  result, held until the next accepted start.
- remainder  out  16  result, held until the next accepted start.
- dbz  out  1  divide-by-zero flag, valid with done.
- err  out  1  path unsupported or guard tripped, valid with done.

## Operation
- Accepted start: on a rising edge with start=1 and busy=0, latch dividend, divisor, base B (decoded from pow10) and near. Clear dbz and err.
- Base complement: c = B - divisor, computed internally at 17 bits. The analyzer's difference output is not used.
- Path selection, evaluated in IDLE on the accepting edge:
  - divisor==0 goes to DONE with quotient=16'hFFFF, remainder=dividend, dbz=1.
  - near=1, B valid and c>=0 goes to ITER (q=0, r=dividend).
  - Otherwise goes to RDIV.
- ITER, one cycle per step:
  - If r<B, go to CORR.
  - Else k=r/B, m=r%B (constant divide, muxed across the three bases); q+=k; r=k*c+m; iteration counter +1.
  - If the counter reaches MAX_ITER with r>=B, go to DONE with err=1, quotient=0, remainder=dividend.
- CORR, one cycle: if r>=divisor then q+=1, r-=divisor. At most one correction is required because c<0.3B. Go to DONE.
- RDIV: 16 shift-subtract cycles, MSB first, with a 17-bit partial remainder. Then go to DONE.
- DONE: done=1, busy=1, quotient and remainder registered. Next state is IDLE.
- start while busy=1 is ignored; there is no queueing.
- Internal widths: r and k*c are 17 bits. The maximum k*c is 65*299 < 2^17, so no overflow occurs.

## Timing
- Reset (asynchronous, immediate): state=IDLE; busy, done, dbz, err=0; quotient=0; remainder=0; iteration counter=0.
- Reset asserted mid-operation aborts the operation. No done pulse follows; the block is idle the first edge after rst deasserts.
- Cycle numbering: start is accepted at edge 0; cycle n is the cycle after edge n.
- Nikhilam path: ITER occupies cycles 1..N+1 for N reduction steps, CORR is cycle N+2, DONE is cycle N+3. The maximum N is 7 (B=10, c=2).
- Restoring path: RDIV occupies cycles 1..16, DONE is cycle 17.
- Divide-by-zero: DONE is cycle 1.
- A new start may be accepted on the edge ending the DONE cycle's successor, i.e. when busy=0.

## Configuration
- NIKHILAM_RESTORE_EN defined: the RDIV state and the restoring datapath are compiled in; every non-zero divisor produces a correct result.
- Not defined: there is no RDIV. Cases that would select it go IDLE→DONE in 1 cycle with err=1, quotient=0, remainder=dividend. The Nikhilam and divide-by-zero paths are unchanged.

## Test plan
- dividend=12345, divisor=9, pow10=10, near=1 -> N=4, done in cycle 7, quotient=1371, remainder=6, err=0.
- dividend=65535, divisor=1000, pow10=8'hE8, near=1 -> c=0, N=1, done in cycle 4, quotient=65, remainder=535.
- dividend=99, divisor=97, pow10=100, near=1 -> N=0, CORR fires, done in cycle 3, quotient=1, remainder=2.
- dividend=50000, divisor=3000, near=0 -> with the macro, done in cycle 17, quotient=16, remainder=2000. Without the macro, done in cycle 1 with err=1.
- divisor=0, dividend=1234 -> done in cycle 1, dbz=1, quotient=16'hFFFF, remainder=1234.
- Reset behaviour, run on 12345/9:
  - start pulsed again in cycle 3 -> ignored, result unchanged.
  - Separately, rst asserted in cycle 3 -> busy=0 immediately and no done pulse.
  - MAX_ITER=2 on 12345/9 -> done with err=1.
